int_priority_sequencer: RTL and testbench
=========================================

Name: int_priority_sequencer

Overview:
Sequences interrupt entry and exit for the write-back stage. Latches edge-triggered requests from four external lines and arbitrates them by fixed priority. Runs a request/acknowledge handshake with the pipeline redirect logic and keeps a return-address/priority stack so ERET resumes the correct context. Replaces the ad-hoc pending/vector logic next to CP0; the EPC and vector outputs feed the PC mux.

Parameters:
DEPTH, 4, nesting stack entries (1..8)
VEC0, 32'd1400, entry PC for source 0
VEC1, 32'd1600, entry PC for source 1
VEC2, 32'd750, entry PC for source 2
VEC3, 32'd950, entry PC for source 3

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the next clk edge)
ir  in  4  raw interrupt lines, level; rising edge = new event
ie  in  1  global interrupt enable from CP0 Status
eret  in  1  one-cycle pulse: ERET retiring in WB
nopc  in  32  next PC of the instruction retiring in WB (return address)
ack  in  1  pipeline has flushed and taken the redirect
int_request  out  1  redirect request, held until ack or cancel
int_num  out  2  source being requested (valid while int_request)
int_pc  out  32  vector for int_num
ret_valid  out  1  one-cycle pulse: ret_pc valid, redirect to it
ret_pc  out  32  popped return address
waiting  out  4  pending flags per source
level  out  4  current stack depth (0..DEPTH)
eret_err  out  1  sticky: ERET with empty stack

Behaviour:
- Reset: all outputs 0, pending=0, edge-detect register ir_q=0, stack cleared, FSM=IDLE.
- Edge detect: pending[i] is set when ir[i]==1 and ir_q[i]==0. ir_q<=ir every cycle. If a clear and a set of the same source fall in one cycle, the set wins.
- Priority: source 3 is highest, source 0 lowest. eligible = pending & mask. mask = sources strictly higher than the priority at the stack top, or all sources when level==0.
- FSM IDLE: if eret, do the pop (below) and stay in IDLE. Else if ie && eligible!=0 && level<DEPTH: latch sel = highest eligible, go to REQ.
- FSM REQ: int_request=1; int_num=sel and int_pc=VEC[sel] stay stable.
  - On ack: push {nopc, sel}, clear pending[sel], level+1, go to IDLE. int_request drops on the next cycle.
  - On eret (has priority over ack in the same cycle): cancel the request with pending kept, do the pop, go to IDLE.
  - A new higher-priority pending source does not preempt a request already issued; sel stays stable until ack or cancel.
  - ie falling in REQ does not cancel the request (the handshake completes).
- Pop: if level>0, assert ret_valid for 1 cycle with ret_pc=top.pc, then level-1. If level==0: no pulse, ret_pc unchanged, eret_err<=1. eret_err is cleared only by reset.
- Latency:
  - ir edge at cycle n: waiting set after edge n+1, int_request high after edge n+2 (with ie=1 and eligible).
  - eret at n: ret_valid high after edge n+1.
- Full stack (level==DEPTH): no new REQ; pending accumulates.
- Reset asserted mid-REQ: request dropped, everything returns to reset values on that edge.
- waiting = pending register; level is a registered count.

Optional Feature:
NESTED_INT_EN
- Defined: nesting as above, up to DEPTH levels, mask by priority.
- Undefined: effective depth 1. No REQ while level!=0, regardless of priority. mask = all sources when level==0. Stack logic reduces to one entry.

Test Plan:
- Reset, then ir=4'b0010 rising, ie=1 -> after 2 edges int_request=1, int_num=1, int_pc=1600. ack=1 -> level=1, waiting=0, int_request=0 next cycle.
- Edges on ir0 and ir2 in the same cycle -> int_num=2, int_pc=750 first. After ack, ir0 stays pending: waiting=4'b0001, no request (0 is lower than 2).
- NESTED_INT_EN defined: serving source 1 with nopc=0x100, ir3 edge -> request int_num=3, int_pc=950. ack with nopc=0x200, then eret -> ret_pc=0x200, level=1. eret -> ret_pc=0x100, level=0.
- eret with level=0 -> no ret_valid, eret_err=1 stays high until rst=0.
- In REQ (int_num=0), eret and ack together -> ret_valid pulse, int_request drops, waiting[0] stays 1, level decremented, not incremented.
- Fill DEPTH=4 with nested entries plus a further edge -> no int_request, waiting bit held. rst=0 mid-REQ -> all outputs 0 after the edge.

Source files
------------

// File: rtl/int_priority_sequencer.sv
// int_priority_sequencer: edge-latched 4-source interrupt arbiter with return stack; `NESTED_INT_EN enables priority nesting
module int_priority_sequencer #(
  parameter int DEPTH = 4,
  parameter logic [31:0] VEC0 = 32'd1400,
  parameter logic [31:0] VEC1 = 32'd1600,
  parameter logic [31:0] VEC2 = 32'd750,
  parameter logic [31:0] VEC3 = 32'd950
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ir,
  input  logic        ie,
  input  logic        eret,
  input  logic [31:0] nopc,
  input  logic        ack,
  output logic        int_request,
  output logic [1:0]  int_num,
  output logic [31:0] int_pc,
  output logic        ret_valid,
  output logic [31:0] ret_pc,
  output logic [3:0]  waiting,
  output logic [3:0]  level,
  output logic        eret_err
);
`ifdef NESTED_INT_EN
  localparam int D = DEPTH;
`else
  localparam int D = DEPTH < 1 ? DEPTH : 1;
`endif
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_n;
  logic [3:0] ir_q, mask, elig, clr;
  logic [1:0] sel, hi;
  logic [2:0] tp;
  logic [31:0] stk_pc [8];
  logic do_push;
  assign tp = 3'(level - 4'd1);
  assign int_request = state == REQ;
  assign int_num = int_request ? sel : 2'd0;
  assign int_pc = !int_request ? 32'd0 : sel == 2'd3 ? VEC3 : sel == 2'd2 ? VEC2 : sel == 2'd1 ? VEC1 : VEC0;
`ifdef NESTED_INT_EN
  logic [1:0] stk_pri [8];
  assign mask = level == 4'd0 ? 4'hf : 4'b1110 << stk_pri[tp];
  // priority of each pushed context, masks equal and lower sources while it is live
  always_ff @(posedge clk)
    if (!rst) stk_pri <= '{default: 2'd0};
    else if (do_push) stk_pri[level[2:0]] <= sel;
`else
  assign mask = level == 4'd0 ? 4'hf : 4'h0;
`endif
  assign elig = waiting & mask;
  assign hi = elig[3] ? 2'd3 : elig[2] ? 2'd2 : elig[1] ? 2'd1 : 2'd0;
  assign clr = do_push ? 4'b0001 << sel : 4'h0;
  // state register
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // eret always wins: it pops and cancels any outstanding request
  always_comb begin
    do_push = state == REQ && ack && !eret;
    state_n = state == REQ ? (eret || ack ? IDLE : REQ) : (!eret && ie && elig != 4'h0 && level < 4'(D) ? REQ : IDLE);
  end
  // edge capture, arbitration latch, return stack and return pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      ir_q <= 4'h0;
      waiting <= 4'h0;
      sel <= 2'd0;
      level <= 4'd0;
      ret_valid <= 1'b0;
      ret_pc <= 32'd0;
      eret_err <= 1'b0;
      stk_pc <= '{default: 32'd0};
    end else begin
      ir_q <= ir;
      waiting <= (waiting & ~clr) | (ir & ~ir_q);
      ret_valid <= eret && level != 4'd0;
      if (state == IDLE && state_n == REQ) sel <= hi;
      if (do_push) begin
        stk_pc[level[2:0]] <= nopc;
        level <= level + 4'd1;
      end
      if (eret && level != 4'd0) begin
        ret_pc <= stk_pc[tp];
        level <= level - 4'd1;
      end
      if (eret && level == 4'd0) eret_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_int_priority_sequencer.sv
// tb_int_priority_sequencer: vector table, directed nesting sequences and randomized reference-model comparison
module tb_int_priority_sequencer;
  logic clk = 1'b0;
  logic rst, ie, eret, ack;
  logic [3:0] ir;
  logic [31:0] nopc;
  logic int_request, ret_valid, eret_err;
  logic [1:0] int_num;
  logic [31:0] int_pc, ret_pc;
  logic [3:0] waiting, level;
  int errors = 0;
  int checks = 0;
`ifdef NESTED_INT_EN
  localparam int DEFF = 4;
  localparam bit NESTED = 1'b1;
`else
  localparam int DEFF = 1;
  localparam bit NESTED = 1'b0;
`endif
  always #5 clk = ~clk;
  int_priority_sequencer dut (
    .clk(clk), .rst(rst), .ir(ir), .ie(ie), .eret(eret), .nopc(nopc), .ack(ack),
    .int_request(int_request), .int_num(int_num), .int_pc(int_pc), .ret_valid(ret_valid),
    .ret_pc(ret_pc), .waiting(waiting), .level(level), .eret_err(eret_err)
  );
  typedef struct {logic [31:0] pc; int pri;} ctx_t;
  ctx_t stk[$];
  logic [3:0] m_pend, m_irq;
  logic m_req, m_rv, m_err;
  int m_sel;
  logic [31:0] m_rpc;
  function automatic logic [31:0] vec(int s);
    return s == 3 ? 32'd950 : s == 2 ? 32'd750 : s == 1 ? 32'd1600 : 32'd1400;
  endfunction
  task automatic model_step();
    logic [3:0] rise;
    ctx_t c;
    if (!rst) begin
      stk.delete();
      m_pend = 4'h0;
      m_irq = 4'h0;
      m_req = 1'b0;
      m_sel = 0;
      m_rv = 1'b0;
      m_rpc = 32'd0;
      m_err = 1'b0;
      return;
    end
    rise = ir & ~m_irq;
    m_rv = 1'b0;
    if (eret) begin
      m_req = 1'b0;
      if (stk.size() > 0) begin
        c = stk.pop_back();
        m_rv = 1'b1;
        m_rpc = c.pc;
      end else m_err = 1'b1;
    end else if (m_req) begin
      if (ack) begin
        c.pc = nopc;
        c.pri = m_sel;
        stk.push_back(c);
        m_pend[m_sel] = 1'b0;
        m_req = 1'b0;
      end
    end else if (ie && stk.size() < DEFF) begin
      for (int i = 3; i >= 0; i--)
        if (!m_req && m_pend[i] && (stk.size() == 0 || (NESTED && i > stk[$].pri))) begin
          m_req = 1'b1;
          m_sel = i;
        end
    end
    m_pend = m_pend | rise;
    m_irq = ir;
  endtask
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic chk_all(string t, logic rq, logic [1:0] num, logic [31:0] pc, logic rv, logic [31:0] rpc, logic [3:0] w, logic [3:0] lv, logic er);
    chk({t, ".int_request"}, 32'(int_request), 32'(rq));
    chk({t, ".int_num"}, 32'(int_num), 32'(num));
    chk({t, ".int_pc"}, int_pc, pc);
    chk({t, ".ret_valid"}, 32'(ret_valid), 32'(rv));
    chk({t, ".ret_pc"}, ret_pc, rpc);
    chk({t, ".waiting"}, 32'(waiting), 32'(w));
    chk({t, ".level"}, 32'(level), 32'(lv));
    chk({t, ".eret_err"}, 32'(eret_err), 32'(er));
  endtask
  task automatic cyc(logic r, logic [3:0] i, logic e, logic er, logic [31:0] pc, logic a);
    rst = r;
    ir = i;
    ie = e;
    eret = er;
    nopc = pc;
    ack = a;
    @(posedge clk);
    model_step();
    #1;
  endtask
  typedef struct {
    logic r; logic [3:0] i; logic e; logic er; logic [31:0] pc; logic a;
    logic rq; logic [1:0] num; logic [31:0] ipc; logic rv; logic [31:0] rpc; logic [3:0] w; logic [3:0] lv; logic err;
  } row_t;
  row_t tbl [17];
  initial begin
    tbl[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 32'd0,    1'b0, 32'h0,   4'b0000, 4'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 32'd0,    1'b0, 32'h0,   4'b0000, 4'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 32'd0,    1'b0, 32'h0,   4'b0010, 4'd0, 1'b0};
    tbl[3]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 2'd1, 32'd1600, 1'b0, 32'h0,   4'b0010, 4'd0, 1'b0};
    tbl[4]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 2'd0, 32'd0,    1'b0, 32'h0,   4'b0000, 4'd1, 1'b0};
    tbl[5]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 2'd0, 32'd0,    1'b1, 32'h100, 4'b0000, 4'd0, 1'b0};
    tbl[6]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 32'd0,    1'b0, 32'h100, 4'b0000, 4'd0, 1'b0};
    tbl[7]  = '{1'b1, 4'b0101, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 32'd0,    1'b0, 32'h100, 4'b0101, 4'd0, 1'b0};
    tbl[8]  = '{1'b1, 4'b0101, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 2'd2, 32'd750,  1'b0, 32'h100, 4'b0101, 4'd0, 1'b0};
    tbl[9]  = '{1'b1, 4'b0101, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 2'd0, 32'd0,    1'b0, 32'h100, 4'b0001, 4'd1, 1'b0};
    tbl[10] = '{1'b1, 4'b0101, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 32'd0,    1'b0, 32'h100, 4'b0001, 4'd1, 1'b0};
    tbl[11] = '{1'b1, 4'b0101, 1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 2'd0, 32'd0,    1'b1, 32'h200, 4'b0001, 4'd0, 1'b0};
    tbl[12] = '{1'b1, 4'b0101, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 2'd0, 32'd1400, 1'b0, 32'h200, 4'b0001, 4'd0, 1'b0};
    tbl[13] = '{1'b1, 4'b0101, 1'b1, 1'b1, 32'h0,   1'b1, 1'b0, 2'd0, 32'd0,    1'b0, 32'h200, 4'b0001, 4'd0, 1'b1};
    tbl[14] = '{1'b1, 4'b0101, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 2'd0, 32'd1400, 1'b0, 32'h200, 4'b0001, 4'd0, 1'b1};
    tbl[15] = '{1'b1, 4'b0101, 1'b1, 1'b0, 32'h300, 1'b1, 1'b0, 2'd0, 32'd0,    1'b0, 32'h200, 4'b0000, 4'd1, 1'b1};
    tbl[16] = '{1'b0, 4'b0101, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 32'd0,    1'b0, 32'h0,   4'b0000, 4'd0, 1'b0};
    for (int k = 0; k < 17; k++) begin
      cyc(tbl[k].r, tbl[k].i, tbl[k].e, tbl[k].er, tbl[k].pc, tbl[k].a);
      chk_all($sformatf("row%0d", k), tbl[k].rq, tbl[k].num, tbl[k].ipc, tbl[k].rv, tbl[k].rpc, tbl[k].w, tbl[k].lv, tbl[k].err);
    end
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 32'h0, 1'b0);
`ifdef NESTED_INT_EN
    for (int s = 0; s < 4; s++) begin
      cyc(1'b1, 4'((5'b00010 << s) - 5'd1), 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 4'((5'b00010 << s) - 5'd1), 1'b1, 1'b0, 32'h0, 1'b0);
      chk($sformatf("nest%0d.int_num", s), 32'(int_num), 32'(s));
      chk($sformatf("nest%0d.int_pc", s), int_pc, vec(s));
      cyc(1'b1, 4'((5'b00010 << s) - 5'd1), 1'b1, 1'b0, 32'(16 * (s + 1)), 1'b1);
      chk($sformatf("nest%0d.level", s), 32'(level), 32'(s + 1));
    end
    cyc(1'b1, 4'b0111, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b0);
    chk_all("full", 1'b0, 2'd0, 32'd0, 1'b0, 32'h0, 4'b1000, 4'd4, 1'b0);
    cyc(1'b1, 4'b1111, 1'b1, 1'b1, 32'h0, 1'b0);
    chk_all("pop4", 1'b0, 2'd0, 32'd0, 1'b1, 32'h40, 4'b1000, 4'd3, 1'b0);
    cyc(1'b1, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b0);
    chk_all("rereq3", 1'b1, 2'd3, 32'd950, 1'b0, 32'h40, 4'b1000, 4'd3, 1'b0);
    cyc(1'b1, 4'b1111, 1'b1, 1'b1, 32'h50, 1'b1);
    chk_all("eret_ack", 1'b0, 2'd0, 32'd0, 1'b1, 32'h30, 4'b1000, 4'd2, 1'b0);
    cyc(1'b1, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b0);
    chk_all("again3", 1'b1, 2'd3, 32'd950, 1'b0, 32'h30, 4'b1000, 4'd2, 1'b0);
`else
    cyc(1'b1, 4'b0001, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b1, 1'b0, 32'h0, 1'b0);
    chk_all("req0", 1'b1, 2'd0, 32'd1400, 1'b0, 32'h0, 4'b0001, 4'd0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b1, 1'b0, 32'h10, 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b1, 4'b1001, 1'b1, 1'b0, 32'h0, 1'b0);
    chk_all("full", 1'b0, 2'd0, 32'd0, 1'b0, 32'h0, 4'b1000, 4'd1, 1'b0);
    cyc(1'b1, 4'b1001, 1'b1, 1'b1, 32'h0, 1'b0);
    chk_all("pop", 1'b0, 2'd0, 32'd0, 1'b1, 32'h10, 4'b1000, 4'd0, 1'b0);
    cyc(1'b1, 4'b1001, 1'b1, 1'b0, 32'h0, 1'b0);
    chk_all("req3", 1'b1, 2'd3, 32'd950, 1'b0, 32'h10, 4'b1000, 4'd0, 1'b0);
`endif
    cyc(1'b0, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b0);
    chk_all("rst_mid_req", 1'b0, 2'd0, 32'd0, 1'b0, 32'h0, 4'b0000, 4'd0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] ni;
      ni = $urandom_range(0, 3) == 0 ? 4'($urandom) : ir;
      cyc($urandom_range(0, 199) != 0, ni, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 2) == 0);
      chk_all("rand", m_req, m_req ? 2'(m_sel) : 2'd0, m_req ? vec(m_sel) : 32'd0, m_rv, m_rpc, m_pend, 4'(stk.size()), m_err);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
